pic_8259: RTL and testbench



---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_priority_resolver.sv | 30 +++
 rtl/pic_8259.sv | 180 ++++++++++++++++++
 tb/tb_pic_8259.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the pic_8259 interrupt controller.
package pic_pkg;

    typedef enum logic [1:0] {
        READY,
        WAIT_ICW2,
        WAIT_ICW4
    } init_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        WAIT2,
        ACK2
    } ack_state_t;

    localparam logic [2:0] OCW2_NSEOI = 3'b001;
    localparam logic [2:0] OCW2_SEOI  = 3'b011;

    localparam logic [4:0] DEF_BASE  = 5'b00001;

    localparam logic [7:0] PORT_CMD  = 8'h20;
    localparam logic [7:0] PORT_DATA = 8'h21;

endpackage

// File: rtl/pic_priority_resolver.sv
// Fixed-priority resolver: IR0 is highest, a request interrupts only above the
// highest in-service level.
module pic_priority_resolver (
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    output logic [2:0] top,
    output logic       req_valid,
    output logic [2:0] isr_top,
    output logic       intr_next
);

    logic [7:0] req;
    logic       isr_valid;

    always_comb begin
        req       = irr & ~imr;
        top       = '0;
        isr_top   = '0;
        // Scan from IR7 down so the lowest set index is the last one written.
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[7 - i]) top = 3'(7 - i);
            if (isr[7 - i]) isr_top = 3'(7 - i);
        end
        req_valid = |req;
        isr_valid = |isr;
        intr_next = req_valid && (!isr_valid || (top < isr_top));
    end

endmodule

// File: rtl/pic_8259.sv
// Simplified 8259A PIC: fixed priority, edge-triggered, single mode.
// Optional automatic EOI is built when PIC_AEOI_EN is defined.
module pic_8259 #(
    parameter logic [4:0] DEF_BASE = pic_pkg::DEF_BASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       a0,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_en,
    input  logic [7:0] ir,
    input  logic       inta_n,
    output logic       intr
);

    import pic_pkg::*;

    logic [7:0]  ir_q;
    logic        wr_n_q;
    logic        inta_n_q;
    logic [7:0]  irr, isr, imr;
    logic [7:0]  irr_nx, isr_nx, imr_nx;
    logic [4:0]  base;
    logic [2:0]  lvl;
    logic        rdsel;
    logic        need_icw4;
    logic        aeoi;

    init_state_t init_state, init_next;
    ack_state_t  ack_state, ack_next;

    logic [2:0]  top, isr_top;
    logic        req_valid, intr_next;

    logic        wr_evt, cmd_wr, data_wr;
    logic        icw1, ocw2, ocw3;
    logic        inta_fall, inta_rise;
    logic        ack_take, grant, aeoi_clr;
    logic [7:0]  ir_edge;

    pic_priority_resolver u_resolver (
        .irr       (irr),
        .imr       (imr),
        .isr       (isr),
        .top       (top),
        .req_valid (req_valid),
        .isr_top   (isr_top),
        .intr_next (intr_next)
    );

    assign wr_evt    = !cs_n && !wr_n && wr_n_q;
    assign cmd_wr    = wr_evt && (a0 == PORT_CMD[0]);
    assign data_wr   = wr_evt && (a0 == PORT_DATA[0]);
    assign icw1      = cmd_wr && din[4];
    assign ocw2      = cmd_wr && (din[4:3] == 2'b00);
    assign ocw3      = cmd_wr && (din[4:3] == 2'b01);
    assign inta_fall = !inta_n && inta_n_q;
    assign inta_rise = inta_n && !inta_n_q;
    assign ir_edge   = ir & ~ir_q;

    assign ack_take  = (ack_state == IDLE) && inta_fall && !icw1;
    // Arbitration uses the registered intr and the pre-edge IRR, so an IR edge
    // landing with the first INTA fall waits for the next acknowledge.
    assign grant     = ack_take && intr && req_valid;
    assign aeoi_clr  = aeoi && (ack_state == ACK2) && inta_rise;

`ifdef PIC_AEOI_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            aeoi <= 1'b0;
        end else if (icw1) begin
            aeoi <= 1'b0;
        end else if (data_wr && (init_state == WAIT_ICW4)) begin
            aeoi <= din[1];
        end
    end
`else
    assign aeoi = 1'b0;
`endif

    always_comb begin
        init_next = init_state;
        if (icw1) begin
            init_next = WAIT_ICW2;
        end else if (data_wr) begin
            case (init_state)
                WAIT_ICW2: init_next = need_icw4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: init_next = READY;
                default:   init_next = init_state;
            endcase
        end
    end

    always_comb begin
        ack_next = ack_state;
        case (ack_state)
            IDLE:    if (inta_fall) ack_next = ACK1;
            ACK1:    if (inta_rise) ack_next = WAIT2;
            WAIT2:   if (inta_fall) ack_next = ACK2;
            ACK2:    if (inta_rise) ack_next = IDLE;
            default: ack_next = IDLE;
        endcase
        if (icw1) ack_next = IDLE;
    end

    // Later updates override earlier ones; ICW1 clears everything last.
    always_comb begin
        irr_nx = irr;
        isr_nx = isr;
        imr_nx = imr;
        if (grant) begin
            isr_nx[top] = 1'b1;
            irr_nx[top] = 1'b0;
        end
        irr_nx = irr_nx | ir_edge;
        if (aeoi_clr) isr_nx[lvl] = 1'b0;
        if (ocw2 && (din[7:5] == OCW2_NSEOI) && (|isr)) isr_nx[isr_top] = 1'b0;
        if (ocw2 && (din[7:5] == OCW2_SEOI)) isr_nx[din[2:0]] = 1'b0;
        if (data_wr && (init_state == READY)) imr_nx = din;
        if (icw1) begin
            irr_nx = '0;
            isr_nx = '0;
            imr_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            wr_n_q     <= 1'b1;
            inta_n_q   <= 1'b1;
            irr        <= '0;
            isr        <= '0;
            imr        <= '1;
            base       <= DEF_BASE;
            lvl        <= '0;
            rdsel      <= 1'b0;
            need_icw4  <= 1'b0;
            intr       <= 1'b0;
            init_state <= READY;
            ack_state  <= IDLE;
        end else begin
            ir_q       <= ir;
            wr_n_q     <= wr_n;
            inta_n_q   <= inta_n;
            irr        <= irr_nx;
            isr        <= isr_nx;
            imr        <= imr_nx;
            init_state <= init_next;
            ack_state  <= ack_next;
            intr       <= (ack_next == IDLE) ? intr_next : 1'b0;
            if (icw1) begin
                need_icw4 <= din[0];
                rdsel     <= 1'b0;
            end else if (ocw3 && din[1]) begin
                rdsel <= din[0];
            end
            if (data_wr && (init_state == WAIT_ICW2)) base <= din[7:3];
            if (ack_take) lvl <= grant ? top : 3'd7;
        end
    end

    always_comb begin
        dout    = 8'hFF;
        dout_en = 1'b0;
        if ((ack_state == ACK2) && !inta_n) begin
            dout    = {base, lvl};
            dout_en = 1'b1;
        end else if (!cs_n && !rd_n && inta_n) begin
            dout_en = 1'b1;
            if (a0 == PORT_DATA[0]) dout = imr;
            else                    dout = rdsel ? isr : irr;
        end
    end

endmodule

// File: tb/tb_pic_8259.sv
// Self-checking bench for pic_8259: directed scenarios plus randomized traffic
// against a transaction-level register model.
module tb_pic_8259;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       a0 = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       inta_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] ir = 8'h00;
    logic [7:0] dout;
    logic       dout_en;
    logic       intr;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_irr, m_isr, m_imr;
    logic [4:0] m_base;
    logic       m_rdsel, m_aeoi, m_need4;
    int         m_phase;

    always #5 clk = ~clk;

    pic_8259 #(.DEF_BASE(5'b00001)) dut (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (cs_n),
        .a0      (a0),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .din     (din),
        .dout    (dout),
        .dout_en (dout_en),
        .ir      (ir),
        .inta_n  (inta_n),
        .intr    (intr)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic m_intr_f();
        logic [7:0] req;
        req = m_irr & ~m_imr;
        if (req == 8'h00) return 1'b0;
        return lowest(req) < lowest(m_isr);
    endfunction

    task automatic m_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_base = 5'b00001;
        m_rdsel = 1'b0; m_aeoi = 1'b0; m_need4 = 1'b0; m_phase = 0;
    endtask

    task automatic m_write(input logic a, input logic [7:0] d);
        int k;
        if (!a && d[4]) begin
            m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_rdsel = 1'b0;
            m_aeoi = 1'b0; m_phase = 1; m_need4 = d[0];
        end else if (a) begin
            if (m_phase == 1) begin
                m_base  = d[7:3];
                m_phase = m_need4 ? 2 : 0;
            end else if (m_phase == 2) begin
`ifdef PIC_AEOI_EN
                m_aeoi = d[1];
`endif
                m_phase = 0;
            end else begin
                m_imr = d;
            end
        end else if (d[4:3] == 2'b00) begin
            if (d[7:5] == 3'b001) begin
                k = lowest(m_isr);
                if (k < 8) m_isr[k] = 1'b0;
            end else if (d[7:5] == 3'b011) begin
                m_isr[d[2:0]] = 1'b0;
            end
        end else if (d[4:3] == 2'b01) begin
            if (d[1]) m_rdsel = d[0];
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
        cyc(1);
        wr_n = 1'b1; cs_n = 1'b1;
        cyc(2);
        m_write(a, d);
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d, output logic en);
        cs_n = 1'b0; a0 = a; rd_n = 1'b0;
        #2;
        d  = dout;
        en = dout_en;
        cyc(1);
        rd_n = 1'b1; cs_n = 1'b1;
        cyc(1);
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] d;
        logic       en;
        bus_write(1'b0, 8'h0A);
        bus_read(1'b0, d, en);
        check({tag, "_irr"}, d, m_irr);
        check({tag, "_irr_en"}, en, 8'd1);
        bus_write(1'b0, 8'h0B);
        bus_read(1'b0, d, en);
        check({tag, "_isr"}, d, m_isr);
        bus_read(1'b1, d, en);
        check({tag, "_imr"}, d, m_imr);
    endtask

    task automatic ir_pulse(input logic [7:0] mask);
        ir = mask;
        cyc(1);
        ir = 8'h00;
        cyc(2);
        m_irr = m_irr | mask;
    endtask

    task automatic inta_ack(input string tag, input logic [7:0] ir_with);
        logic [7:0] req, v;
        logic [2:0] lvl;
        logic       en;
        req = m_irr & ~m_imr;
        if (m_intr_f()) begin
            lvl = 3'(lowest(req));
            m_isr[lvl] = 1'b1;
            m_irr[lvl] = 1'b0;
        end else begin
            lvl = 3'd7;
        end
        m_irr = m_irr | ir_with;
        inta_n = 1'b0; ir = ir | ir_with;
        cyc(1);
        ir = ir & ~ir_with;
        cyc(1);
        check({tag, "_intr_low"}, intr, 8'd0);
        inta_n = 1'b1;
        cyc(2);
        inta_n = 1'b0;
        cyc(1);
        #2;
        v  = dout;
        en = dout_en;
        check({tag, "_vec"}, v, {m_base, lvl});
        check({tag, "_vec_en"}, en, 8'd1);
        cyc(1);
        inta_n = 1'b1;
        cyc(2);
        if (m_aeoi) m_isr[lvl] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] d;
        logic       en;
        bit         found;
        int         op;

        m_reset();
        rst = 1'b1;
        cyc(3);
        check("rst_intr", intr, 8'd0);
        check("rst_dout", dout, 8'hFF);
        check("rst_dout_en", dout_en, 8'd0);
        rst = 1'b0;
        cyc(1);
        bus_read(1'b1, d, en);
        check("rst_imr", d, 8'hFF);
        bus_read(1'b0, d, en);
        check("rst_irr", d, 8'h00);

        // 1: init and first acknowledge
        bus_write(1'b0, 8'h13);
        bus_write(1'b1, 8'h08);
        bus_write(1'b1, 8'h01);
        bus_write(1'b1, 8'hFE);
        ir = 8'h01;
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            cyc(1);
            if (intr) found = 1'b1;
        end
        ir = 8'h00;
        cyc(2);
        m_irr = m_irr | 8'h01;
        check("t1_intr_3clk", found, 8'd1);
        inta_ack("t1", 8'h00);
        check_regs("t1");

        // 2: two simultaneous requests, non-specific EOI
        bus_write(1'b0, 8'h20);
        bus_write(1'b1, 8'h00);
        ir_pulse(8'h28);
        check("t2_intr", intr, 8'd1);
        inta_ack("t2a", 8'h00);
        check("t2_intr_blocked", intr, 8'(m_intr_f()));
        bus_write(1'b0, 8'h20);
        check("t2_intr_after_eoi", intr, 8'd1);
        inta_ack("t2b", 8'h00);
        bus_write(1'b0, 8'h20);

        // 3: lower-priority request blocked by ISR, specific EOI
        ir_pulse(8'h04);
        inta_ack("t3a", 8'h00);
        ir_pulse(8'h40);
        check("t3_intr_blocked", intr, 8'd0);
        bus_write(1'b0, 8'h62);
        check("t3_intr_after_seoi", intr, 8'd1);
        inta_ack("t3b", 8'h00);
        bus_write(1'b0, 8'h20);

        // IR edge coincident with the first INTA fall is not arbitrated
        ir_pulse(8'h20);
        inta_ack("edge_a", 8'h02);
        check("edge_intr", intr, 8'(m_intr_f()));
        inta_ack("edge_b", 8'h00);
        bus_write(1'b0, 8'h20);
        bus_write(1'b0, 8'h20);

        // 4: spurious acknowledge
        inta_ack("t4", 8'h00);
        check_regs("t4");

        // masked request stays pending
        bus_write(1'b1, 8'h10);
        ir_pulse(8'h10);
        check("mask_intr", intr, 8'd0);
        check_regs("mask");
        bus_write(1'b1, 8'h00);
        check("unmask_intr", intr, 8'd1);
        inta_ack("unmask", 8'h00);
        bus_write(1'b0, 8'h20);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 6));
            case (op)
                0, 1: ir_pulse(8'($urandom_range(1, 255)));
                2, 3: inta_ack("rnd", 8'h00);
                4: bus_write(1'b0, 8'h20);
                5: bus_write(1'b0, {5'b01100, 3'($urandom_range(0, 7))});
                default: bus_write(1'b1, 8'($urandom) & 8'($urandom));
            endcase
            check("rnd_intr", intr, 8'(m_intr_f()));
            if ((it % 16) == 15) check_regs("rnd");
        end

`ifdef PIC_AEOI_EN
        bus_write(1'b0, 8'h13);
        bus_write(1'b1, 8'h08);
        bus_write(1'b1, 8'h03);
        bus_write(1'b1, 8'h00);
        ir_pulse(8'h02);
        inta_ack("aeoi", 8'h00);
        check_regs("aeoi");
`endif

        // 6: reset in WAIT2
        bus_write(1'b0, 8'h13);
        bus_write(1'b1, 8'h08);
        bus_write(1'b1, 8'h01);
        bus_write(1'b1, 8'h00);
        ir_pulse(8'h08);
        inta_n = 1'b0;
        cyc(2);
        inta_n = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("rstw2_intr", intr, 8'd0);
        check("rstw2_dout", dout, 8'hFF);
        check("rstw2_dout_en", dout_en, 8'd0);
        rst = 1'b0;
        cyc(1);
        m_reset();
        check_regs("rstw2");
        inta_ack("rstw2_spur", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
